// File: rtl/mealy_seq.sv
// -----------------------------------------------------------------------------
// mealy_seq -- serial "1100" detector, Mealy style, overlapping detection.
//
// One bit of x is consumed per rising edge of clock, oldest bit first. The
// detect flag z is combinational. It is high while the machine holds "110"
// and the current x is 0, so it asserts in the same cycle as the final 0.
//
// Ports
//   clock  in   1  system clock; all state updates on the rising edge
//   reset  in   1  synchronous active-high reset (also forces z low)
//   x      in   1  serial data bit
//   z      out  1  detect flag; high while "1100" is completed by x
// -----------------------------------------------------------------------------
module mealy_seq (
    input  logic clock,
    input  logic reset,
    input  logic x,
    output logic z
);

    // Binary state encoding. The names record the longest useful prefix
    // seen so far.
    localparam logic [1:0] S0 = 2'b00;  // idle, no useful prefix
    localparam logic [1:0] S1 = 2'b01;  // "1"
    localparam logic [1:0] S2 = 2'b10;  // "11"
    localparam logic [1:0] S3 = 2'b11;  // "110"

    logic [1:0] state;
    logic [1:0] state_next;

    // -------------------------------------------------------------------------
    // State register. Reset is sampled only on the clock edge.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignment in clocked logic, so every register
        // samples pre-edge values regardless of statement order.
        if (reset)
            state <= S0;
        else
            state <= state_next;
    end

    // -------------------------------------------------------------------------
    // Next-state logic.
    // A run of extra 1s keeps the machine in S2, because "11" is still the
    // useful suffix. After a completed match, the trailing "0" is not a prefix
    // of "1100", so the machine falls back to S0. Any unknown encoding lands
    // on the default branch and recovers to S0 on the next edge.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default assigned first so every path drives state_next; without
        // it a missed branch would infer a latch.
        state_next = S0;
        case (state)
            S0:      state_next = x ? S1 : S0;
            S1:      state_next = x ? S2 : S0;
            S2:      state_next = x ? S2 : S3;
            S3:      state_next = x ? S1 : S0;
            default: state_next = S0;
        endcase
    end

    // Mealy output. It is gated by reset, so an asserted reset also silences
    // a match that is pending in S3.
    assign z = (state == S3) && !x && !reset;

endmodule

// File: tb/tb_mealy_seq.sv
// -----------------------------------------------------------------------------
// tb_mealy_seq -- directed bench for mealy_seq.
//
// Timing: clock period 10, first rising edge at t=5, inputs change on the
// falling edge (t=10, 20, ...). Each bit is checked twice:
//   pre  : t+4, before the edge that consumes the bit
//   post : t+6, after that edge, with x still holding the same bit
// Every expected value below was worked out by hand from the state table.
// -----------------------------------------------------------------------------
module tb_mealy_seq;

    logic clock;
    logic reset;
    logic x;
    logic z;

    int vectors = 0;
    int miscompares = 0;

    mealy_seq dut (
        .clock (clock),
        .reset (reset),
        .x     (x),
        .z     (z)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: z=%b, expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One bit period, entered on a falling edge and left on the next one.
    task automatic step(input logic xb, input logic rb,
                        input logic exp_pre, input logic exp_post,
                        input string tag);
        x     = xb;
        reset = rb;
        #4;
        check({tag, "/pre"}, z, exp_pre);
        #2;
        check({tag, "/post"}, z, exp_post);
        #4;
    endtask

    // Applies n bits with reset low. The vectors are left-aligned: bit 15 is
    // the first bit applied.
    task automatic run(input string tag, input int n,
                       input logic [15:0] xs, input logic [15:0] pre,
                       input logic [15:0] post);
        for (int i = 0; i < n; i++)
            step(xs[15-i], 1'b0, pre[15-i], post[15-i],
                 $sformatf("%s[%0d]", tag, i + 1));
    endtask

    // One reset edge with x held at 1, to show that x is ignored under reset.
    task automatic do_reset(input string tag);
        step(1'b1, 1'b1, 1'b0, 1'b0, tag);
    endtask

    initial begin
        reset = 1'b1;
        x     = 1'b0;
        #2;
        check("reset_before_edge", z, 1'b0);
        #5;
        check("reset_after_edge", z, 1'b0);
        #3;  // t=10

        // Long stream. z is high over 45-55, 95-105 and 135-145.
        // post samples: bits 4, 9, 13. pre samples: bits 5, 10, 14.
        run("stream", 15,
            16'b1110011100110010,
            16'b0000100001000100,
            16'b0001000010001000);

        // Back-to-back "1100" gives two detections, four cycles apart.
        do_reset("rst_a");
        run("back2back", 8,
            16'b1100110000000000,
            16'b0001000100000000,
            16'b0010001000000000);

        // "110" then 1 takes the S3 -> S1 path, and "1100" completes later.
        do_reset("rst_b");
        run("s3_to_s1", 7,
            16'b1101100000000000,
            16'b0000001000000000,
            16'b0010010000000000);

        // Reset in S3 with x=0 must force z low and discard the partial match.
        do_reset("rst_c");
        run("mid_reset", 3,
            16'b1100000000000000,
            16'b0000000000000000,
            16'b0010000000000000);
        step(1'b0, 1'b1, 1'b0, 1'b0, "mid_reset/pulse");
        step(1'b0, 1'b0, 1'b0, 1'b0, "mid_reset/zero1");
        step(1'b0, 1'b0, 1'b0, 1'b0, "mid_reset/zero2");

        // Ten 1s then "00". The machine holds S2 and detects once.
        do_reset("rst_d");
        run("long_ones", 12,
            16'b1111111111000000,
            16'b0000000000010000,
            16'b0000000000100000);

        // In S3, z follows NOT x between edges with no clock involved.
        do_reset("rst_e");
        run("track_setup", 3,
            16'b1100000000000000,
            16'b0000000000000000,
            16'b0010000000000000);
        x = 1'b1; #1; check("track/x1a", z, 1'b0);
        x = 1'b0; #1; check("track/x0a", z, 1'b1);
        x = 1'b1; #1; check("track/x1b", z, 1'b0);
        x = 1'b0; #1; check("track/x0b", z, 1'b1);
        #2;  // past the edge: S3 with x=0 returns to S0
        check("track/after_edge", z, 1'b0);
        #4;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
